// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory port between fetch and data, one outstanding transaction.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetchReq,
  input  logic [ADDR_WIDTH-1:0]   fetchAdr,
  output logic [DATA_WIDTH-1:0]   fetchRdata,
  output logic                    fetchValid,
  input  logic                    dataReq,
  input  logic                    dataWriteEn,
  input  logic [ADDR_WIDTH-1:0]   dataAdr,
  input  logic [DATA_WIDTH-1:0]   dataWdata,
  input  logic [DATA_WIDTH/8-1:0] dataByteEn,
  output logic [DATA_WIDTH-1:0]   dataRdata,
  output logic                    dataValid,
  output logic                    memReq,
  output logic                    memWriteEn,
  output logic [ADDR_WIDTH-1:0]   memAdr,
  output logic [DATA_WIDTH-1:0]   memWdata,
  output logic [DATA_WIDTH/8-1:0] memByteEn,
  input  logic                    memReady,
  input  logic [DATA_WIDTH-1:0]   memRdata,
  input  logic                    memRvalid,
  output logic                    StallFetch,
  output logic                    StallData
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {FETCH, DATA} owner_t;
  state_t state, state_nx;
  owner_t owner;
  logic done, arb, grant_data, force_fetch;
  if (DATA_WIDTH % 8 != 0 || STARVE_LIMIT < 1) begin : g_cfg_check
    $error("memory_port_arbiter: unsupported parameter combination");
  end
  // Completion is suppressed during reset so an aborted transaction never pulses Valid.
  assign done       = state == RESP && memRvalid && !reset;
  assign fetchValid = done && owner == FETCH;
  assign dataValid  = done && owner == DATA;
  assign fetchRdata = memRdata;
  assign dataRdata  = memRdata;
  assign StallFetch = fetchReq & ~fetchValid;
  assign StallData  = dataReq & ~dataValid;
  // Stall terms double as pending requests: the completing requester is masked.
  assign arb        = (state == IDLE || done) && (StallFetch || StallData);
  assign grant_data = StallData && !(force_fetch && StallFetch);
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve;
  always_ff @(posedge clk)
    if (reset || !fetchReq || (arb && !grant_data))
      starve <= '0;
    else if (arb && starve != CW'(STARVE_LIMIT))
      starve <= starve + 1'b1;
  assign force_fetch = starve == CW'(STARVE_LIMIT);
`else
  assign force_fetch = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = arb ? REQ :
               state == REQ  ? (memReady ? RESP : REQ) :
               state == RESP ? (memRvalid ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      owner      <= FETCH;
      memReq     <= 1'b0;
      memWriteEn <= 1'b0;
      memAdr     <= '0;
      memWdata   <= '0;
      memByteEn  <= '0;
    end else if (arb) begin
      owner      <= grant_data ? DATA : FETCH;
      memReq     <= 1'b1;
      memWriteEn <= grant_data & dataWriteEn;
      memAdr     <= grant_data ? dataAdr : fetchAdr;
      memWdata   <= grant_data ? dataWdata : '0;
      memByteEn  <= grant_data ? dataByteEn : '1;
    end else if (state == REQ && memReady) begin
      memReq     <= 1'b0;
    end
endmodule
